gw_tap_delay_line: RTL and testbench

//  Parametrised, clock-enabled, multi-tap delay line (register chain) for Gowin designs simulated under Verilator.

---
 rtl/gw_tap_delay_line_pkg.sv | 29 ++
 rtl/gw_tap_delay_line_if.sv | 30 +++
 rtl/gw_tap_delay_line_dffre.sv | 26 ++
 rtl/gw_tap_delay_line.sv | 77 +++++++
 tb/tb_gw_tap_delay_line.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gw_tap_delay_line_pkg.sv
// Shared helpers for the Gowin sim-model delay line: width math
// and the legal DEPTH range.
package gw_sim_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  function automatic int aw_of(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cw_of(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/gw_tap_delay_line_if.sv
// Data/tap bundle of the delay line: the master drives enable,
// data and tap select; the slave returns tap data, valid and fill.
interface gw_tap_delay_line_if
  import gw_sim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);

  localparam int AW = aw_of(DEPTH);
  localparam int CW = cw_of(DEPTH);

  logic             CE;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    ADDR;
  logic [WIDTH-1:0] Q;
  logic             Q_VLD;
  logic [CW-1:0]    FILL;

  modport master (
    output CE, D, ADDR,
    input  Q, Q_VLD, FILL
  );

  modport slave (
    input  CE, D, ADDR,
    output Q, Q_VLD, FILL
  );

endinterface

// File: rtl/gw_tap_delay_line_dffre.sv
// WIDTH-bit register with clock enable and synchronous reset
// to INIT; powers up holding INIT as well.
module gw_dffre_w #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r = INIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r <= INIT;
    end else if (ce) begin
      r <= d;
    end
  end

  assign q = r;

endmodule

// File: rtl/gw_tap_delay_line.sv
// Clock-enabled register chain with a clamped runtime tap and a
// saturating fill count that qualifies the tapped data.
module gw_tap_delay_line
  import gw_sim_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  gw_tap_delay_line_if.slave bus
);

  localparam int AW = aw_of(DEPTH);
  localparam int CW = cw_of(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("gw_tap_delay_line: DEPTH must be within 1..64");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign din = bus.D;
    end else begin : g_link
      assign din = stage[i-1];
    end
    gw_dffre_w #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_reg (
      .clk   (CLK),
      .reset (RESET),
      .ce    (bus.CE),
      .d     (din),
      .q     (stage[i])
    );
  end

  // Saturates at DEPTH so a long CE run never reports an empty line.
  logic [CW-1:0] fill_cnt = '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fill_cnt <= '0;
    end else if (bus.CE && fill_cnt != FULL) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  logic [AW-1:0] eff;

  always_comb begin
    eff = bus.ADDR;
    if (32'(bus.ADDR) > 32'(DEPTH - 1)) begin
      eff = AW'(DEPTH - 1);
    end
  end

  logic [WIDTH-1:0] tap;

  always_comb begin
    tap = stage[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (32'(eff) == 32'(i)) tap = stage[i];
    end
  end

  assign bus.Q     = tap;
  assign bus.Q_VLD = 32'(fill_cnt) > 32'(eff);
  assign bus.FILL  = fill_cnt;

endmodule

// File: tb/tb_gw_tap_delay_line.sv
// Bench for gw_tap_delay_line: DEPTH 4, 5 and 1 instances share
// one stimulus stream and are checked against a queue model.
module tb_gw_tap_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ce;
  logic [7:0] d;
  logic [1:0] a4;
  logic [2:0] a5;
  logic       a1;

  int checks = 0;
  int errors = 0;

  gw_tap_delay_line_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  gw_tap_delay_line_if #(.WIDTH(8), .DEPTH(5)) if5 ();
  gw_tap_delay_line_if #(.WIDTH(8), .DEPTH(1)) if1 ();

  assign if4.CE   = ce;
  assign if4.D    = d;
  assign if4.ADDR = a4;
  assign if5.CE   = ce;
  assign if5.D    = d;
  assign if5.ADDR = a5;
  assign if1.CE   = ce;
  assign if1.D    = d;
  assign if1.ADDR = a1;

  gw_tap_delay_line #(
    .WIDTH (8),
    .DEPTH (4),
    .INIT  (8'hA5)
  ) u4 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if4)
  );

  gw_tap_delay_line #(
    .WIDTH (8),
    .DEPTH (5),
    .INIT  (8'h3C)
  ) u5 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if5)
  );

  gw_tap_delay_line #(
    .WIDTH (8),
    .DEPTH (1),
    .INIT  (8'h5A)
  ) u1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if1)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: newest-first history of enabled samples since reset.
  logic [7:0] h4[$];
  logic [7:0] h5[$];
  logic [7:0] h1[$];

  always @(posedge clk) begin
    if (rst) begin
      h4.delete();
      h5.delete();
      h1.delete();
    end else if (ce) begin
      h4.push_front(d);
      h5.push_front(d);
      h1.push_front(d);
      if (h4.size() > 64) h4.pop_back();
      if (h5.size() > 64) h5.pop_back();
      if (h1.size() > 64) h1.pop_back();
    end
  end

  function automatic int clampi(input int a, input int depth);
    return (a > depth - 1) ? depth - 1 : a;
  endfunction

  function automatic logic [7:0] tap_val(
    input logic [7:0] h[$],
    input int         eff,
    input logic [7:0] init
  );
    if (eff < h.size()) return h[eff];
    return init;
  endfunction

  function automatic int fill_of(input int n, input int depth);
    return (n > depth) ? depth : n;
  endfunction

  always @(negedge clk) begin
    int e;
    e = clampi(int'(a4), 4);
    chk("u4.Q", 32'(if4.Q), 32'(tap_val(h4, e, 8'hA5)));
    chk("u4.Q_VLD", 32'(if4.Q_VLD), 32'(h4.size() > e));
    chk("u4.FILL", 32'(if4.FILL), 32'(fill_of(h4.size(), 4)));
    e = clampi(int'(a5), 5);
    chk("u5.Q", 32'(if5.Q), 32'(tap_val(h5, e, 8'h3C)));
    chk("u5.Q_VLD", 32'(if5.Q_VLD), 32'(h5.size() > e));
    chk("u5.FILL", 32'(if5.FILL), 32'(fill_of(h5.size(), 5)));
    e = clampi(int'(a1), 1);
    chk("u1.Q", 32'(if1.Q), 32'(tap_val(h1, e, 8'h5A)));
    chk("u1.Q_VLD", 32'(if1.Q_VLD), 32'(h1.size() > e));
    chk("u1.FILL", 32'(if1.FILL), 32'(fill_of(h1.size(), 1)));
  end

  task automatic step(
    input logic       r,
    input logic       c,
    input logic [7:0] dv
  );
    rst = r;
    ce  = c;
    d   = dv;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] t2q [6];
  logic       t2v [6];
  logic [2:0] t2f [6];
  logic [7:0] t5q [6];
  logic       t5v [6];
  logic [2:0] t5f [6];

  initial begin
    t2q = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    t2v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t2f = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    t5q = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h30, 8'h31};
    t5v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t5f = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};

    rst = 1'b0;
    ce  = 1'b0;
    d   = 8'h00;
    a4  = 2'd0;
    a5  = 3'd7;
    a1  = 1'b1;

    // Power-up state before any reset
    @(posedge clk);
    #2;
    chk("pwr.Q", 32'(if4.Q), 32'h A5);
    chk("pwr.FILL", 32'(if4.FILL), 32'd0);

    // Reset, then sweep all taps while holding
    step(1'b1, 1'b0, 8'h00);
    for (int a = 0; a < 4; a++) begin
      a4 = 2'(a);
      step(1'b0, 1'b0, 8'h77);
      chk("t1.Q", 32'(if4.Q), 32'hA5);
      chk("t1.Q_VLD", 32'(if4.Q_VLD), 32'd0);
      chk("t1.FILL", 32'(if4.FILL), 32'd0);
    end

    // Continuous CE into tap 2, fill saturates at 4
    a4 = 2'd2;
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, 8'(n + 1));
      chk("t2.Q", 32'(if4.Q), 32'(t2q[n]));
      chk("t2.Q_VLD", 32'(if4.Q_VLD), 32'(t2v[n]));
      chk("t2.FILL", 32'(if4.FILL), 32'(t2f[n]));
    end

    // Alternating CE on tap 0
    step(1'b1, 1'b0, 8'h00);
    a4 = 2'd0;
    step(1'b0, 1'b1, 8'h10);
    chk("t3.Q0", 32'(if4.Q), 32'h10);
    chk("t3.F0", 32'(if4.FILL), 32'd1);
    step(1'b0, 1'b0, 8'h11);
    chk("t3.Q1", 32'(if4.Q), 32'h10);
    chk("t3.F1", 32'(if4.FILL), 32'd1);
    step(1'b0, 1'b1, 8'h12);
    chk("t3.Q2", 32'(if4.Q), 32'h12);
    chk("t3.F2", 32'(if4.FILL), 32'd2);
    step(1'b0, 1'b0, 8'h13);
    chk("t3.Q3", 32'(if4.Q), 32'h12);
    chk("t3.F3", 32'(if4.FILL), 32'd2);

    step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b1, 8'h21);
    step(1'b0, 1'b1, 8'h22);
    chk("fill.Q", 32'(if4.Q), 32'h22);
    chk("fill.F", 32'(if4.FILL), 32'd4);

    // Reset wins over a simultaneous shift
    step(1'b1, 1'b1, 8'hFF);
    chk("t4.Q", 32'(if4.Q), 32'hA5);
    chk("t4.Q_VLD", 32'(if4.Q_VLD), 32'd0);
    chk("t4.FILL", 32'(if4.FILL), 32'd0);
    a4 = 2'd3;
    #1;
    chk("t4.Q3", 32'(if4.Q), 32'hA5);
    chk("t1.u1.Q", 32'(if1.Q), 32'h5A);
    chk("t1.u1.V", 32'(if1.Q_VLD), 32'd0);

    // Clamped taps on DEPTH 5 and DEPTH 1
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, 8'(8'h30 + n));
      chk("t5.Q", 32'(if5.Q), 32'(t5q[n]));
      chk("t5.Q_VLD", 32'(if5.Q_VLD), 32'(t5v[n]));
      chk("t5.FILL", 32'(if5.FILL), 32'(t5f[n]));
      chk("t6.Q_VLD", 32'(if1.Q_VLD), 32'd1);
      chk("t6.FILL", 32'(if1.FILL), 32'd1);
    end
    chk("t6.Q", 32'(if1.Q), 32'h35);
    chk("t5.u4.Q", 32'(if4.Q), 32'h32);
    step(1'b0, 1'b0, 8'h99);
    chk("t6.hold", 32'(if1.Q), 32'h35);

    // Mixed pattern with a mid-run reset
    for (int i = 0; i < 40; i++) begin
      a4 = 2'(i % 4);
      a5 = 3'(i % 8);
      a1 = 1'(i % 2);
      step(i == 25, (i % 3) != 0, 8'(i * 37 + 5));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
